// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/clear buttons, BCD time base
// with saturation at 99:59:59.99, and an 8-digit multiplexed display.

module stopwatch_debounce #(
    parameter int CNT = 4
) (
    input  logic i_clk,
    input  logic w_rst,
    input  logic btn,
    output logic press
);
    localparam int W = (CNT < 1) ? 1 : $clog2(CNT + 1);

    logic         sync1;
    logic         sync2;
    logic [W-1:0] cnt;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive high cycles; pulse once on the CNT-th, then
    // saturate so a held button cannot re-trigger until released.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= sync2 && (cnt == W'(CNT - 1));
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt != W'(CNT)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int DEBOUNCE_CNT = 20'hF_FFFF,
    parameter int SCAN_DIV     = 100_000
) (
    input  logic       i_clk,
    input  logic       w_rst,
    input  logic       i_start,
    input  logic       i_clear,
    output logic [7:0] o_an,
    output logic [3:0] o_digit,
    output logic       o_dp,
    output logic       o_running,
    output logic       o_sat
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Last value before saturation: 99:59:59.98 as packed BCD nibbles.
    localparam logic [31:0] LAST_M1 = 32'h9959_5998;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        SAT
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           start_p;
    logic           clear_p;
    logic           clr_time;
    logic           tick;
    logic [PW-1:0]  presc_q;
    logic [31:0]    time_q;
    logic [31:0]    time_d;
    logic [SW-1:0]  scan_q;
    logic [2:0]     idx_q;

    stopwatch_debounce #(.CNT(DEBOUNCE_CNT)) u_start_db (
        .i_clk (i_clk),
        .w_rst (w_rst),
        .btn   (i_start),
        .press (start_p)
    );

    stopwatch_debounce #(.CNT(DEBOUNCE_CNT)) u_clear_db (
        .i_clk (i_clk),
        .w_rst (w_rst),
        .btn   (i_clear),
        .press (clear_p)
    );

    assign tick = (state_q == RUN) && (presc_q == PW'(DIV - 1));

    // State register.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; reaching the final count wins over a start press so
    // a paused watch can never hold 99:59:59.99 and later wrap.
    always_comb begin
        state_d  = state_q;
        clr_time = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_p) begin
                    clr_time = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick && (time_q == LAST_M1)) begin
                    state_d = SAT;
                end else if (start_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d  = IDLE;
                    clr_time = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            SAT: begin
                if (clear_p) begin
                    state_d  = IDLE;
                    clr_time = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler runs only while staying in RUN; any other state or a
    // fresh RUN entry discards the partial tick.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            presc_q <= '0;
        end else if (state_q != RUN || state_d != RUN || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Cascaded BCD increment; tens of seconds and minutes stop at 5.
    always_comb begin
        logic       carry;
        logic [3:0] lim;
        time_d = time_q;
        carry  = tick;
        lim    = 4'd9;
        for (int i = 0; i < 8; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (time_q[i*4 +: 4] == lim) begin
                    time_d[i*4 +: 4] = 4'd0;
                end else begin
                    time_d[i*4 +: 4] = time_q[i*4 +: 4] + 4'd1;
                end
            end
            carry = carry && (time_q[i*4 +: 4] == lim);
        end
        if (clr_time) begin
            time_d = '0;
        end
    end

    // Time register.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    // Free-running scan divider and digit index.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= idx_q + 3'd1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    // Registered display and status outputs, all from the same cycle.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            o_an      <= 8'hFE;
            o_digit   <= 4'd0;
            o_dp      <= 1'b0;
            o_running <= 1'b0;
            o_sat     <= 1'b0;
        end else begin
            o_an      <= ~(8'h01 << idx_q);
            o_digit   <= time_q[{idx_q, 2'b00} +: 4];
            o_dp      <= (idx_q == 3'd2) || (idx_q == 3'd4) ||
                         (idx_q == 3'd6);
            o_running <= (state_d == RUN);
            o_sat     <= (state_d == SAT);
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small divider parameters.
// Time is preloaded with force to reach the end of range quickly.

module tb_stopwatch_ctrl;
    logic       i_clk = 1'b0;
    logic       w_rst;
    logic       i_start;
    logic       i_clear;
    logic [7:0] o_an;
    logic [3:0] o_digit;
    logic       o_dp;
    logic       o_running;
    logic       o_sat;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    stopwatch_ctrl #(
        .CLK_HZ       (1000),
        .TICK_HZ      (100),
        .DEBOUNCE_CNT (4),
        .SCAN_DIV     (2)
    ) dut (
        .i_clk     (i_clk),
        .w_rst     (w_rst),
        .i_start   (i_start),
        .i_clear   (i_clear),
        .o_an      (o_an),
        .o_digit   (o_digit),
        .o_dp      (o_dp),
        .o_running (o_running),
        .o_sat     (o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Counts accepted start presses.
    always @(posedge i_clk) begin
        if (dut.start_p) pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset;
        w_rst   = 1'b1;
        i_start = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(negedge i_clk);
        w_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic press(input logic st, input logic cl, input int hold);
        i_start = st;
        i_clear = cl;
        repeat (hold) @(negedge i_clk);
        i_start = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic wait_running(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge i_clk);
            if (o_running) begin
                lat = n;
                break;
            end
        end
        i_start = 1'b0;
    endtask

    task automatic read_display(output logic [31:0] val,
                                output logic [7:0] dps);
        val = '0;
        dps = '0;
        for (int n = 0; n < 16; n++) begin
            @(negedge i_clk);
            for (int k = 0; k < 8; k++) begin
                if (o_an[k] == 1'b0) begin
                    val[k*4 +: 4] = o_digit;
                    dps[k]        = o_dp;
                end
            end
        end
    endtask

    task automatic test_reset;
        w_rst   = 1'b1;
        i_start = 1'b0;
        i_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_an !== 8'hFE) begin
            failures++;
            $display("FAIL reset_an got=%h exp=fe", o_an);
        end
        checks++;
        if (o_digit !== 4'd0) begin
            failures++;
            $display("FAIL reset_digit got=%h exp=0", o_digit);
        end
        checks++;
        if (o_dp !== 1'b0 || o_running !== 1'b0 || o_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b exp=000",
                     o_dp, o_running, o_sat);
        end
        checks++;
        if (dut.time_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_time got=%h exp=0", dut.time_q);
        end
        w_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_scan;
        logic [7:0] exp_an;
        logic       exp_dp;
        int         idx;
        bit         found;
        do_reset();
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (o_an == 8'hFD) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL scan_start got=%h exp=fd", o_an);
            return;
        end
        for (int k = 0; k < 18; k++) begin
            idx    = (1 + k / 2) % 8;
            exp_an = ~(8'h01 << idx);
            exp_dp = (idx == 2) || (idx == 4) || (idx == 6);
            checks++;
            if (o_an !== exp_an || o_dp !== exp_dp) begin
                failures++;
                $display("FAIL scan_step%0d got an=%h dp=%b exp an=%h dp=%b",
                         k, o_an, o_dp, exp_an, exp_dp);
            end
            checks++;
            if (o_digit !== 4'd0) begin
                failures++;
                $display("FAIL scan_digit%0d got=%h exp=0", k, o_digit);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_debounce;
        int p0;
        do_reset();
        p0 = pulses;
        for (int g = 0; g < 3; g++) begin
            press(1'b1, 1'b0, 2);
            repeat (3) @(negedge i_clk);
        end
        press(1'b1, 1'b0, 3);
        @(negedge i_clk);
        press(1'b1, 1'b0, 3);
        repeat (6) @(negedge i_clk);
        checks++;
        if (pulses - p0 !== 0 || o_running !== 1'b0) begin
            failures++;
            $display("FAIL glitch got pulses=%0d run=%b exp pulses=0 run=0",
                     pulses - p0, o_running);
        end
        press(1'b1, 1'b0, 10);
        repeat (10) @(negedge i_clk);
        checks++;
        if (pulses - p0 !== 1 || o_running !== 1'b1) begin
            failures++;
            $display("FAIL hold got pulses=%0d run=%b exp pulses=1 run=1",
                     pulses - p0, o_running);
        end
    endtask

    task automatic test_run;
        int          lat;
        logic [31:0] val;
        logic [7:0]  dps;
        do_reset();
        i_start = 1'b1;
        wait_running(lat);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL run_latency got=%0d exp=7", lat);
        end
        repeat (9) @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h0) begin
            failures++;
            $display("FAIL run_pre_tick got=%h exp=0", dut.time_q);
        end
        @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h1) begin
            failures++;
            $display("FAIL run_first_tick got=%h exp=1", dut.time_q);
        end
        repeat (240) @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h25) begin
            failures++;
            $display("FAIL run_25 got=%h exp=25", dut.time_q);
        end
        press(1'b1, 1'b0, 8);
        checks++;
        if (o_running !== 1'b0) begin
            failures++;
            $display("FAIL run_pause got=%b exp=0", o_running);
        end
        read_display(val, dps);
        checks++;
        if (val !== 32'h0000_0025 || dps !== 8'h54) begin
            failures++;
            $display("FAIL run_display got=%h dp=%h exp=00000025 dp=54",
                     val, dps);
        end
    endtask

    task automatic test_carry;
        int          lat;
        logic [31:0] val;
        logic [7:0]  dps;
        do_reset();
        force dut.time_q = 32'h0000_5999;
        @(negedge i_clk);
        release dut.time_q;
        i_start = 1'b1;
        wait_running(lat);
        repeat (9) @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h0000_5999) begin
            failures++;
            $display("FAIL carry_hold got=%h exp=00005999", dut.time_q);
        end
        @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h0001_0000) begin
            failures++;
            $display("FAIL carry_min got=%h exp=00010000", dut.time_q);
        end
        press(1'b1, 1'b0, 8);
        force dut.time_q = 32'h9959_5998;
        @(negedge i_clk);
        release dut.time_q;
        i_start = 1'b1;
        wait_running(lat);
        repeat (9) @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h9959_5998 || o_sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_pre got=%h sat=%b exp=99595998 sat=0",
                     dut.time_q, o_sat);
        end
        @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h9959_5999 || o_sat !== 1'b1 ||
            o_running !== 1'b0) begin
            failures++;
            $display("FAIL sat_enter got=%h sat=%b run=%b exp=99595999 1 0",
                     dut.time_q, o_sat, o_running);
        end
        repeat (10) @(negedge i_clk);
        checks++;
        if (dut.time_q !== 32'h9959_5999 || o_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_frozen got=%h sat=%b exp=99595999 sat=1",
                     dut.time_q, o_sat);
        end
        read_display(val, dps);
        checks++;
        if (val !== 32'h9959_5999) begin
            failures++;
            $display("FAIL sat_display got=%h exp=99595999", val);
        end
        press(1'b1, 1'b0, 8);
        repeat (4) @(negedge i_clk);
        checks++;
        if (o_sat !== 1'b1 || o_running !== 1'b0 ||
            dut.time_q !== 32'h9959_5999) begin
            failures++;
            $display("FAIL sat_start got sat=%b run=%b t=%h exp 1 0 99595999",
                     o_sat, o_running, dut.time_q);
        end
        press(1'b0, 1'b1, 8);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_sat !== 1'b0 || dut.time_q !== 32'h0) begin
            failures++;
            $display("FAIL sat_clear got sat=%b t=%h exp sat=0 t=0",
                     o_sat, dut.time_q);
        end
    endtask

    task automatic test_simul;
        int          lat;
        logic [31:0] val;
        logic [7:0]  dps;
        do_reset();
        i_start = 1'b1;
        wait_running(lat);
        repeat (10) @(negedge i_clk);
        press(1'b0, 1'b1, 8);
        checks++;
        if (o_running !== 1'b1 || dut.time_q !== 32'h1) begin
            failures++;
            $display("FAIL run_clear got run=%b t=%h exp run=1 t=1",
                     o_running, dut.time_q);
        end
        repeat (12) @(negedge i_clk);
        press(1'b1, 1'b1, 8);
        checks++;
        if (o_running !== 1'b0 || dut.time_q !== 32'h3) begin
            failures++;
            $display("FAIL both_run got run=%b t=%h exp run=0 t=3",
                     o_running, dut.time_q);
        end
        repeat (5) @(negedge i_clk);
        press(1'b1, 1'b1, 8);
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_running !== 1'b0 || dut.time_q !== 32'h0) begin
            failures++;
            $display("FAIL both_pause got run=%b t=%h exp run=0 t=0",
                     o_running, dut.time_q);
        end
        read_display(val, dps);
        checks++;
        if (val !== 32'h0) begin
            failures++;
            $display("FAIL both_display got=%h exp=0", val);
        end
    endtask

    task automatic test_async_reset;
        int lat;
        do_reset();
        i_start = 1'b1;
        wait_running(lat);
        repeat (23) @(negedge i_clk);
        checks++;
        if (o_running !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got run=%b exp=1", o_running);
        end
        @(posedge i_clk);
        #2 w_rst = 1'b1;
        #1;
        checks++;
        if (o_an !== 8'hFE || o_digit !== 4'd0 || o_dp !== 1'b0) begin
            failures++;
            $display("FAIL async_display got an=%h d=%h dp=%b exp fe 0 0",
                     o_an, o_digit, o_dp);
        end
        checks++;
        if (o_running !== 1'b0 || o_sat !== 1'b0 ||
            dut.time_q !== 32'h0) begin
            failures++;
            $display("FAIL async_state got run=%b sat=%b t=%h exp 0 0 0",
                     o_running, o_sat, dut.time_q);
        end
        @(negedge i_clk);
        w_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_held_reset;
        int p0;
        w_rst   = 1'b1;
        i_start = 1'b1;
        i_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        p0    = pulses;
        w_rst = 1'b0;
        repeat (6) @(negedge i_clk);
        checks++;
        if (o_running !== 1'b0) begin
            failures++;
            $display("FAIL held_early got run=%b exp=0", o_running);
        end
        @(negedge i_clk);
        checks++;
        if (o_running !== 1'b1) begin
            failures++;
            $display("FAIL held_start got run=%b exp=1", o_running);
        end
        repeat (10) @(negedge i_clk);
        checks++;
        if (pulses - p0 !== 1 || o_running !== 1'b1) begin
            failures++;
            $display("FAIL held_once got pulses=%0d run=%b exp 1 1",
                     pulses - p0, o_running);
        end
        i_start = 1'b0;
    endtask

    initial begin
        w_rst   = 1'b1;
        i_start = 1'b0;
        i_clear = 1'b0;
        test_reset();
        test_scan();
        test_debounce();
        test_run();
        test_carry();
        test_simul();
        test_async_reset();
        test_held_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
